apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge.sv | 143 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding CPU request/response port to APB.
// Decodes the slave index from the address, runs the APB SETUP/ACCESS
// handshake with per-slave psel, tolerates wait states up to TIMEOUT and
// returns a one-cycle response carrying read data or an error.
module apb_master_bridge #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             NUM_SLAVES = 4,
    parameter int unsigned             SEL_LSB    = 12,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned             TIMEOUT    = 255
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [ADDR_WIDTH-1:0]            req_addr_i,
    input  logic                             req_write_i,
    input  logic [DATA_WIDTH-1:0]            req_wdata_i,
    output logic                             rsp_valid_o,
    output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
    output logic                             rsp_err_o,
    output logic [ADDR_WIDTH-1:0]            paddr_o,
    output logic [NUM_SLAVES-1:0]            psel_o,
    output logic                             penable_o,
    output logic                             pwrite_o,
    output logic [DATA_WIDTH-1:0]            pwdata_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i,
    input  logic [NUM_SLAVES-1:0]            pready_i,
    input  logic [NUM_SLAVES-1:0]            pslverr_i
);

    localparam int unsigned IDX_W   = $clog2(NUM_SLAVES);
    localparam int unsigned TAG_LSB = SEL_LSB + IDX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [7:0]            wait_cnt;

    logic [IDX_W-1:0]      req_idx;
    logic [NUM_SLAVES-1:0] req_onehot;
    logic                  decode_hit;

    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    assign req_ready_o = (state == ST_IDLE);
    assign req_idx     = req_addr_i[SEL_LSB +: IDX_W];
    assign req_onehot  = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << req_idx;
    assign decode_hit  = (req_addr_i[ADDR_WIDTH-1:TAG_LSB] == BASE_ADDR[ADDR_WIDTH-1:TAG_LSB]);

    // Route only the latched slave's ready/error/data back to the FSM.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_ready = pready_i[k];
                sel_err   = pslverr_i[k];
                sel_rdata = prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transaction FSM; every APB and response output is registered here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            idx         <= '0;
            wait_cnt    <= '0;
            psel_o      <= '0;
            penable_o   <= 1'b0;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        if (decode_hit) begin
                            idx       <= req_idx;
                            paddr_o   <= req_addr_i;
                            pwrite_o  <= req_write_i;
                            pwdata_o  <= req_wdata_i;
                            psel_o    <= req_onehot;
                            penable_o <= 1'b0;
                            state     <= ST_SETUP;
                        end else begin
                            // Unmapped address: answer immediately, bus untouched.
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    penable_o <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        // pready takes priority over a timeout on the same cycle.
                        psel_o      <= '0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= sel_err;
                        rsp_rdata_o <= (pwrite_o || sel_err) ? '0 : sel_rdata;
                        state       <= ST_RESP;
                    end else if (wait_cnt == 8'(TIMEOUT)) begin
                        psel_o      <= '0;
                        penable_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases with literal
// expectations plus randomized transactions against a per-transaction
// timeline model (response offset, select window, expected payload).
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           req_valid_i;
    logic           req_ready_o;
    logic [AW-1:0]  req_addr_i;
    logic           req_write_i;
    logic [DW-1:0]  req_wdata_i;
    logic           rsp_valid_o;
    logic [DW-1:0]  rsp_rdata_o;
    logic           rsp_err_o;
    logic [AW-1:0]  paddr_o;
    logic [NS-1:0]  psel_o;
    logic           penable_o;
    logic           pwrite_o;
    logic [DW-1:0]  pwdata_o;
    logic [NS*DW-1:0] prdata_i;
    logic [NS-1:0]  pready_i;
    logic [NS-1:0]  pslverr_i;

    always #5 clk_i = ~clk_i;

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
        .SEL_LSB(12), .BASE_ADDR(BASE), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
        .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Current transaction as seen by the model
    logic        tx_active = 1'b0;
    logic        rst_chk   = 1'b1;
    int          tx_a;
    logic        tx_hit;
    logic        tx_wr;
    int          tx_idx;
    logic [31:0] tx_addr;
    logic [31:0] tx_wdata;
    logic [31:0] tx_prd;
    int          tx_w;
    logic        tx_perr;

    // What the driver observed during the last transaction
    int          seen_rel;
    int          seen_cnt;
    logic [31:0] seen_rdata;
    logic        seen_err;
    logic [3:0]  seen_psel0;
    logic [3:0]  seen_psel_or;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outputs derived from the transaction timeline:
    // offset 0 = first cycle after acceptance.
    task automatic check_cycle();
        int         rel;
        int         m;
        logic       to;
        logic [3:0] oh;
        if (rst_chk) begin
            chk("rst_psel", psel_o, 0);
            chk("rst_penable", penable_o, 0);
            chk("rst_paddr", paddr_o, 0);
            chk("rst_pwrite", pwrite_o, 0);
            chk("rst_pwdata", pwdata_o, 0);
            chk("rst_rsp_valid", rsp_valid_o, 0);
            chk("rst_rsp_rdata", rsp_rdata_o, 0);
            chk("rst_rsp_err", rsp_err_o, 0);
            chk("rst_ready", req_ready_o, 1);
        end else if (!tx_active) begin
            chk("idle_psel", psel_o, 0);
            chk("idle_penable", penable_o, 0);
            chk("idle_rsp_valid", rsp_valid_o, 0);
            chk("idle_ready", req_ready_o, 1);
        end else begin
            rel = cyc - tx_a;
            if (!tx_hit) begin
                chk("miss_psel", psel_o, 0);
                chk("miss_penable", penable_o, 0);
                chk("miss_rsp_valid", rsp_valid_o, rel == 0);
                chk("miss_ready", req_ready_o, rel > 0);
                if (rel == 0) begin
                    chk("miss_err", rsp_err_o, 1);
                    chk("miss_rdata", rsp_rdata_o, 0);
                end
            end else begin
                m  = (tx_w <= TO) ? tx_w : TO;
                to = (tx_w > TO);
                oh = 4'(1 << tx_idx);
                chk("psel", psel_o, (rel <= 1 + m) ? oh : 4'b0);
                chk("penable", penable_o, (rel >= 1) && (rel <= 1 + m));
                chk("rsp_valid", rsp_valid_o, rel == 2 + m);
                chk("ready", req_ready_o, rel > 2 + m);
                if (rel <= 2 + m) begin
                    chk("paddr", paddr_o, tx_addr);
                    chk("pwrite", pwrite_o, tx_wr);
                    chk("pwdata", pwdata_o, tx_wdata);
                end
                if (rel == 2 + m) begin
                    chk("rsp_err", rsp_err_o, to || tx_perr);
                    chk("rsp_rdata", rsp_rdata_o, (to || tx_perr || tx_wr) ? 32'h0 : tx_prd);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            check_cycle();
        end
    end

    task automatic noise();
        prdata_i  = {$urandom, $urandom, $urandom, $urandom};
        pready_i  = 4'($urandom);
        pslverr_i = 4'($urandom);
    endtask

    // Target slave follows the planned wait count; everything else is noise.
    task automatic drive_slaves(input int rel);
        logic rdy;
        noise();
        if (tx_hit && rel >= 1) begin
            rdy = (rel - 1 >= tx_w);
            pready_i[tx_idx] = rdy;
            if (rdy) begin
                pslverr_i[tx_idx] = tx_perr;
                prdata_i[tx_idx*DW +: DW] = tx_prd;
            end
        end
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int w, input logic perr, input logic [31:0] prd, input int rst_at);
        int rel;
        int endr;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_write_i = wr;
        req_wdata_i = wdata;
        tx_hit   = (addr[31:14] == BASE[31:14]);
        tx_idx   = int'(addr[13:12]);
        tx_addr  = addr;
        tx_wr    = wr;
        tx_wdata = wdata;
        tx_w     = w;
        tx_perr  = perr;
        tx_prd   = prd;
        tx_a     = cyc + 1;
        tx_active = 1'b1;
        noise();
        endr = tx_hit ? 2 + ((w <= TO) ? w : TO) : 0;
        seen_cnt = 0;
        seen_rel = -1;
        seen_rdata = '0;
        seen_err = 1'b0;
        seen_psel0 = '0;
        seen_psel_or = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            req_addr_i  = $urandom;
            req_write_i = 1'($urandom);
            req_wdata_i = $urandom;
            rel = cyc - tx_a;
            drive_slaves(rel);
            if (rel == 0) seen_psel0 = psel_o;
            seen_psel_or = seen_psel_or | psel_o;
            if (rsp_valid_o) begin
                seen_cnt++;
                seen_rel   = rel;
                seen_rdata = rsp_rdata_o;
                seen_err   = rsp_err_o;
            end
            if (rel == rst_at) begin
                reset_i   = 1'b1;
                rst_chk   = 1'b1;
                tx_active = 1'b0;
                @(negedge clk_i);
                reset_i = 1'b0;
                rst_chk = 1'b0;
                break;
            end
            if (rel >= endr) break;
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            req_addr_i  = $urandom;
            noise();
        end
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          w;
        reset_i     = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_write_i = 1'b0;
        req_wdata_i = '0;
        noise();
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        rst_chk = 1'b0;
        gap(2);

        // Zero-wait read of slave 1
        run_txn(32'h4000_1000, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0001, -1);
        chk("t1_latency", seen_rel, 2);
        chk("t1_rdata", seen_rdata, 32'hA5A5_0001);
        chk("t1_err", seen_err, 0);
        chk("t1_psel_setup", seen_psel0, 4'b0010);
        chk("t1_rsp_count", seen_cnt, 1);

        // Write with three wait states on slave 0
        run_txn(32'h4000_0004, 1'b1, 32'h0000_0055, 3, 1'b0, 32'hDEAD_BEEF, -1);
        chk("t2_latency", seen_rel, 5);
        chk("t2_rdata", seen_rdata, 0);
        chk("t2_err", seen_err, 0);

        // Slave error on slave 2
        run_txn(32'h4000_2008, 1'b0, 32'h0, 1, 1'b1, 32'h1234_5678, -1);
        chk("t3_err", seen_err, 1);
        chk("t3_rdata", seen_rdata, 0);

        // Slave 3 never ready: timeout
        run_txn(32'h4000_3000, 1'b0, 32'h0, 255, 1'b0, 32'h5555_AAAA, -1);
        chk("t4_latency", seen_rel, 10);
        chk("t4_err", seen_err, 1);
        chk("t4_rdata", seen_rdata, 0);

        // Decode miss
        run_txn(32'h5000_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0, -1);
        chk("t5_latency", seen_rel, 0);
        chk("t5_err", seen_err, 1);
        chk("t5_no_psel", seen_psel_or, 0);

        // pready arriving exactly when the counter reaches TIMEOUT
        run_txn(32'h4000_0010, 1'b0, 32'h0, TO, 1'b0, 32'h1234_5678, -1);
        chk("t6_latency", seen_rel, 10);
        chk("t6_err", seen_err, 0);
        chk("t6_rdata", seen_rdata, 32'h1234_5678);

        // Reset in the middle of an ACCESS wait, then a clean read
        run_txn(32'h4000_1020, 1'b0, 32'h0, 5, 1'b0, 32'hCAFE_0000, 3);
        chk("t7_no_rsp", seen_cnt, 0);
        run_txn(32'h4000_1024, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0001, -1);
        chk("t7_after_latency", seen_rel, 2);
        chk("t7_after_rdata", seen_rdata, 32'hCAFE_0001);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
                if (a[31:14] == BASE[31:14]) a[31] = ~a[31];
            end else begin
                a = {BASE[31:14], 2'($urandom_range(0, 3)), 12'($urandom)};
            end
            r = $urandom_range(0, 11);
            w = (r == 11) ? 255 : r;
            run_txn(a, 1'($urandom), $urandom, w, ($urandom_range(0, 4) == 0), $urandom, -1);
            if (seen_cnt != 1) begin
                chk("rnd_rsp_count", seen_cnt, 1);
            end
            gap($urandom_range(0, 2));
        end

        gap(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
